terminal_qsys_ddr_fb_swap_ctrl: RTL

- Avalon-MM slave that owns two DDR frame-buffer base addresses and sequences double buffering between a DDR frame writer (back buffer) and a display reader (front buffer).
- Drives the writer's base address and start/hold, and the reader's base address.
- Swaps buffers only at a reader frame boundary (vsync) after the writer has completed a frame, so the displayed buffer is never torn.
- CPU configures the addresses and enable, and can poll status or take a per-swap interrupt.

---
 rtl/terminal_qsys_ddr_fb_swap_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/terminal_qsys_ddr_fb_swap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | terminal_qsys_ddr_fb_swap_ctrl: Avalon-MM controlled DDR frame-buffer swap   |
// | sequencer. Rev 1.0                                                           |
// +------------------------------------------------------------------------------+
module terminal_qsys_ddr_fb_swap_ctrl #(
  parameter logic [31:0] DEFAULT_BASE0 = 32'h0000_0000,
  parameter logic [31:0] DEFAULT_BASE1 = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        frame_done,
  input  logic        vsync,
  output logic [31:0] rd_base,
  output logic [31:0] wr_base,
  output logic        wr_start,
  output logic        wr_hold,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_DISABLED   = 2'd0,
    ST_FILL       = 2'd1,
    ST_WAIT_VSYNC = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_BASE0    = 3'd0;
  localparam logic [2:0] ADDR_BASE1    = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_SWAP_CNT = 3'd4;

  state_t      state_q,     state_d;
  logic [31:0] base0_q,     base0_d;
  logic [31:0] base1_q,     base1_d;
  logic        enable_q,    enable_d;
  logic        irq_en_q,    irq_en_d;
  logic        front_idx_q, front_idx_d;
  logic [31:0] swap_cnt_q,  swap_cnt_d;
  logic        irq_pend_q,  irq_pend_d;
  logic        wr_start_q,  wr_start_d;
  logic        wr_hold_q,   wr_hold_d;

  logic bus_wr;
  logic swap;

  assign bus_wr = chipselect & ~write_n;

  always_comb begin
    base0_d     = base0_q;
    base1_d     = base1_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    state_d     = state_q;
    front_idx_d = front_idx_q;
    swap_cnt_d  = swap_cnt_q;
    irq_pend_d  = irq_pend_q;
    wr_start_d  = 1'b0;
    swap        = 1'b0;

    if (bus_wr) begin
      case (address)
        ADDR_BASE0: base0_d = writedata;
        ADDR_BASE1: base1_d = writedata;
        ADDR_CTRL: begin
          enable_d = writedata[0];
          irq_en_d = writedata[1];
        end
        default: ;
      endcase
    end

    // The sequencer sees a CTRL write in the same cycle, so disabling wins over a coincident vsync.
    if (!enable_d) begin
      state_d = ST_DISABLED;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d    = ST_FILL;
          wr_start_d = 1'b1;
        end
        ST_FILL: begin
          if (frame_done && vsync) begin
            swap       = 1'b1;
            wr_start_d = 1'b1;
          end else if (frame_done) begin
            state_d = ST_WAIT_VSYNC;
          end
        end
        ST_WAIT_VSYNC: begin
          if (vsync) begin
            swap       = 1'b1;
            state_d    = ST_FILL;
            wr_start_d = 1'b1;
          end
        end
        default: state_d = ST_DISABLED;
      endcase
    end

    if (bus_wr && address == ADDR_STATUS && writedata[3]) begin
      irq_pend_d = 1'b0;
    end

    if (swap) begin
      front_idx_d = ~front_idx_q;
      swap_cnt_d  = swap_cnt_q + 32'd1;
      irq_pend_d  = 1'b1;
    end

    wr_hold_d = (state_q != ST_FILL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_DISABLED;
      base0_q     <= DEFAULT_BASE0;
      base1_q     <= DEFAULT_BASE1;
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      front_idx_q <= 1'b0;
      swap_cnt_q  <= 32'd0;
      irq_pend_q  <= 1'b0;
      wr_start_q  <= 1'b0;
      wr_hold_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      base0_q     <= base0_d;
      base1_q     <= base1_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      front_idx_q <= front_idx_d;
      swap_cnt_q  <= swap_cnt_d;
      irq_pend_q  <= irq_pend_d;
      wr_start_q  <= wr_start_d;
      wr_hold_q   <= wr_hold_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_BASE0:    readdata = base0_q;
      ADDR_BASE1:    readdata = base1_q;
      ADDR_CTRL:     readdata = {30'd0, irq_en_q, enable_q};
      ADDR_STATUS:   readdata = {28'd0, irq_pend_q, state_q, front_idx_q};
      ADDR_SWAP_CNT: readdata = swap_cnt_q;
      default:       readdata = 32'd0;
    endcase
  end

  assign rd_base  = front_idx_q ? base1_q : base0_q;
  assign wr_base  = front_idx_q ? base0_q : base1_q;
  assign wr_start = wr_start_q;
  assign wr_hold  = wr_hold_q;
  assign irq      = irq_pend_q & irq_en_q;

endmodule
`default_nettype wire
